// File: rtl/invert_pkg.sv
// invert_pkg: shared constants for the bit-serial two's-complement negator
package invert_pkg;
    localparam int DEFAULT_WORD_LEN = 0;
    localparam int DEFAULT_CNT_W    = 16;
endpackage

// File: rtl/invert_bitcnt.sv
// invert_bitcnt: modulo-WORD_LEN bit counter flagging the last bit of each word
//   t_clk    in  clock, rising edge
//   r        in  asynchronous active-low reset
//   last_bit out high during the final bit of a word; always low when WORD_LEN = 0
module invert_bitcnt
    import invert_pkg::*;
#(
    parameter int WORD_LEN = DEFAULT_WORD_LEN,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input  logic t_clk,
    input  logic r,
    output logic last_bit
);
    localparam logic             ENABLED = WORD_LEN != 0;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(ENABLED ? WORD_LEN - 1 : 0);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // with WORD_LEN = 0 the counter is held at zero and last_bit is tied low
    always_comb begin
        last_bit = ENABLED && (cnt_q == LAST);
        cnt_d    = (!ENABLED || last_bit) ? '0 : cnt_q + CNT_W'(1);
    end
    always_ff @(posedge t_clk or negedge r) begin
        if (!r) cnt_q <= '0;
        else    cnt_q <= cnt_d;
    end
endmodule

// File: rtl/invert.sv
// invert: bit-serial two's-complement negator, LSB first, zero latency
//   i     in  serial operand bit
//   r     in  asynchronous active-low reset
//   t_clk in  clock, rising edge
//   y     out negated bit, combinational from i and state
module invert
    import invert_pkg::*;
#(
    parameter int WORD_LEN = DEFAULT_WORD_LEN,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input  logic i,
    input  logic r,
    input  logic t_clk,
    output logic y
);
    logic found_q, found_d, last_bit;
    invert_bitcnt #(.WORD_LEN(WORD_LEN), .CNT_W(CNT_W)) u_bitcnt (
        .t_clk   (t_clk),
        .r       (r),
        .last_bit(last_bit)
    );
    // bits after the first 1 are inverted; the word boundary re-arms the search
    always_comb begin
        found_d = last_bit ? 1'b0 : (found_q | i);
        y       = i ^ found_q;
    end
    always_ff @(posedge t_clk or negedge r) begin
        if (!r) found_q <= 1'b0;
        else    found_q <= found_d;
    end
endmodule

// File: tb/tb_invert.sv
// tb_invert: scoreboard bench for invert with WORD_LEN = 0, 4 and 1 side by side
module tb_invert;
    logic t_clk = 1'b0;
    logic r     = 1'b0;
    logic i     = 1'b0;
    logic y0, y4, y1;
    int checks = 0;
    int errors = 0;
    logic exp_q[3][$];
    logic [63:0] acc[3];
    int k[3];
    int wl[3] = '{0, 4, 1};

    always #5 t_clk = ~t_clk;

    invert #(.WORD_LEN(0)) dut0 (.i(i), .r(r), .t_clk(t_clk), .y(y0));
    invert #(.WORD_LEN(4)) dut4 (.i(i), .r(r), .t_clk(t_clk), .y(y4));
    invert #(.WORD_LEN(1)) dut1 (.i(i), .r(r), .t_clk(t_clk), .y(y1));

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            acc[d] = '0;
            k[d]   = 0;
        end
    endtask

    // expected bit k of a word is bit k of the negated partial word value
    function automatic logic model_bit(input int d, input logic b);
        logic [63:0] neg;
        logic e;
        acc[d] = acc[d] | (64'(b) << k[d]);
        neg = -acc[d];
        e = neg[k[d]];
        k[d]++;
        if (wl[d] != 0 && k[d] == wl[d]) begin
            acc[d] = '0;
            k[d]   = 0;
        end
        return e;
    endfunction

    // drive one bit after a falling edge, compare just before the rising edge that registers it
    task automatic send(input logic b);
        logic got[3];
        @(negedge t_clk);
        #1 i = b;
        for (int d = 0; d < 3; d++) exp_q[d].push_back(r ? model_bit(d, b) : b);
        #3;
        got = '{y0, y4, y1};
        for (int d = 0; d < 3; d++) check($sformatf("wl%0d bit", wl[d]), got[d], exp_q[d].pop_front());
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int n = 0; n < 4; n++) send(w[n]);
    endtask

    // asynchronous pulse between a rising and a falling edge
    task automatic pulse_reset();
        @(posedge t_clk);
        #1 r = 1'b0;
        model_reset();
        #2 r = 1'b1;
    endtask

    initial begin
        model_reset();
        r = 1'b0;
        #1;
        check("reset y0", y0, 1'b0);
        send(1'b1);
        send(1'b0);
        send(1'b1);
        @(posedge t_clk);
        #1 r = 1'b1;
        foreach (wl[d]) begin
        end
        send(1'b0); send(1'b0); send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        pulse_reset();
        send(1'b1); send(1'b1);
        pulse_reset();
        send(1'b0); send(1'b1); send(1'b1);
        pulse_reset();
        send_word(4'b0001);
        send_word(4'b0101);
        send_word(4'b0000);
        send_word(4'b1000);
        send_word(4'b0110);
        pulse_reset();
        send(1'b1);
        send(1'b1);
        @(posedge t_clk);
        #2 i = 1'b1;
        #1 check("async pre y0", y0, 1'b0);
        r = 1'b0;
        model_reset();
        #1 check("async y0", y0, 1'b1);
        check("async y4", y4, 1'b1);
        @(posedge t_clk);
        #1 r = 1'b1;
        for (int n = 0; n < 40; n++) send(1'(($urandom_range(0, 3) == 0) ? 1 : 0));
        pulse_reset();
        for (int n = 0; n < 40; n++) send(1'($urandom_range(0, 1)));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
